// File: rtl/discr_cmd_pkg.sv
// discr_cmd_pkg: register map, ctrl bit layout and FSM states
// shared by the discrete-command sequencer and its bus engine.
package discr_cmd_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_INT    = 2'd2;
    localparam logic [1:0] REG_MASK   = 2'd3;

    localparam int CTRL_VWET    = 0;
    localparam int CTRL_THS_INT = 1;
    localparam int CTRL_THS_SEL = 2;
    localparam int CTRL_SENSE   = 3;

    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 27;

    typedef enum logic [2:0] {
        INIT_CTRL,
        INIT_MASK,
        IDLE,
        WR_CTRL,
        WR_MASK,
        RD_INT,
        RD_STAT,
        PUBLISH
    } seq_state_t;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_REQ,
        TXN_RDV
    } txn_state_t;

    // cfg nibble {sense, ths_sel, ths_int, vwet} placed in reg 0
    function automatic logic [31:0] ctrl_word(input logic [3:0] c);
        ctrl_word = '0;
        ctrl_word[CTRL_VWET]    = c[0];
        ctrl_word[CTRL_THS_INT] = c[1];
        ctrl_word[CTRL_THS_SEL] = c[2];
        ctrl_word[CTRL_SENSE]   = c[3];
    endfunction

endpackage

// File: rtl/discr_avm_txn.sv
// discr_avm_txn: one Avalon-MM read or write at a time,
// with a per-phase stall/readdatavalid timeout.
module discr_avm_txn #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata
);
    import discr_cmd_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    txn_state_t      st;
    logic [CW-1:0]   cnt;
    logic            phase_end;

    assign phase_end = (cnt == CW'(TIMEOUT - 1));

    // request/accept/readdatavalid handshake with phase timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= TXN_IDLE;
            cnt           <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            rdata         <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (st)
                TXN_IDLE: begin
                    if (start) begin
                        avm_address   <= addr;
                        avm_writedata <= wdata;
                        avm_read      <= rnw;
                        avm_write     <= ~rnw;
                        cnt           <= '0;
                        st            <= TXN_REQ;
                    end
                end
                TXN_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        cnt       <= '0;
                        if (avm_read) begin
                            st <= TXN_RDV;
                        end else begin
                            done <= 1'b1;
                            st   <= TXN_IDLE;
                        end
                    end else if (phase_end) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        timeout   <= 1'b1;
                        st        <= TXN_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TXN_RDV: begin
                    if (avm_readdatavalid) begin
                        rdata <= avm_readdata;
                        done  <= 1'b1;
                        st    <= TXN_IDLE;
                    end else if (phase_end) begin
                        timeout <= 1'b1;
                        st      <= TXN_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= TXN_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/discr_cmd_sequencer.sv
// discr_cmd_sequencer: configures and services one discrete-input
// slave. Define DC_POLL_TIMER_EN for periodic forced polls.
module discr_cmd_sequencer #(
    parameter int COUNT       = 27,
    parameter int TIMEOUT     = 255,
    parameter int POLL_PERIOD = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cfg_ctrl,
    input  logic [COUNT-1:0] cfg_mask,
    input  logic             cfg_valid,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic             avm_waitrequest,
    input  logic             avm_readdatavalid,
    input  logic [31:0]      avm_readdata,
    input  logic             irq_in,
    output logic             snap_valid,
    output logic [COUNT-1:0] snap_status,
    output logic [COUNT-1:0] snap_int,
    output logic [4:0]       snap_addr,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clr
);
    import discr_cmd_pkg::*;

    if (COUNT < 1 || COUNT > 27 || TIMEOUT < 1 || POLL_PERIOD < 1)
    begin : g_bad_cfg
        $error("discr_cmd_sequencer: bad parameter value");
    end

    seq_state_t       state;
    logic             start;
    logic             txn_done;
    logic             txn_timeout;
    logic             rnw;
    logic [1:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [3:0]       ctrl_q;
    logic [COUNT-1:0] mask_q;
    logic [COUNT-1:0] int_q;
    logic             cfg_pend;
    logic             irq_pend;
    logic             poll_pend;
    logic             go_cfg;
    logic             go_rd;

    assign go_cfg = (state == IDLE) & cfg_pend;
    assign go_rd  = (state == IDLE) & ~cfg_pend & (irq_pend | poll_pend);

    // register address and write data for the current bus state
    always_comb begin
        rnw   = 1'b0;
        addr  = REG_CTRL;
        wdata = '0;
        unique case (1'b1)
            (state == INIT_MASK): addr = REG_MASK;
            (state == WR_CTRL):   wdata = ctrl_word(ctrl_q);
            (state == WR_MASK): begin
                addr  = REG_MASK;
                wdata = {{(32-COUNT){1'b0}}, mask_q};
            end
            (state == RD_INT): begin
                rnw  = 1'b1;
                addr = REG_INT;
            end
            (state == RD_STAT): begin
                rnw  = 1'b1;
                addr = REG_STATUS;
            end
            default: ;
        endcase
    end

    // pending work flags; a new request wins over the entry clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_pend <= 1'b0;
            irq_pend <= 1'b0;
            ctrl_q   <= '0;
            mask_q   <= '0;
        end else begin
            cfg_pend <= cfg_valid | (cfg_pend & ~go_cfg);
            irq_pend <= irq_in | (irq_pend & ~go_rd);
            if (cfg_valid) begin
                ctrl_q <= cfg_ctrl;
                mask_q <= cfg_mask;
            end
        end
    end

`ifdef DC_POLL_TIMER_EN
    localparam int PW = $clog2(POLL_PERIOD + 1);

    logic [PW-1:0] poll_cnt;
    logic          poll_hit;

    assign poll_hit = (poll_cnt == PW'(POLL_PERIOD - 1));

    // free-running poll timer, restarted by every snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            poll_pend <= poll_hit | (poll_pend & ~go_rd);
            if (state == PUBLISH || poll_hit) begin
                poll_cnt <= '0;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end
`else
    assign poll_pend = 1'b0;
`endif

    // sequencer FSM; start resets high so init begins at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT_CTRL;
            start       <= 1'b1;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            int_q       <= '0;
            snap_valid  <= 1'b0;
            snap_status <= '0;
            snap_int    <= '0;
            snap_addr   <= '0;
        end else begin
            start      <= 1'b0;
            snap_valid <= 1'b0;
            if (txn_timeout) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
            if (txn_timeout) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    INIT_CTRL: begin
                        if (txn_done) begin
                            state <= INIT_MASK;
                            start <= 1'b1;
                        end
                    end
                    INIT_MASK, WR_MASK: begin
                        if (txn_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    IDLE: begin
                        if (go_cfg) begin
                            state <= WR_CTRL;
                            start <= 1'b1;
                            busy  <= 1'b1;
                        end else if (go_rd) begin
                            state <= RD_INT;
                            start <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    WR_CTRL: begin
                        if (txn_done) begin
                            state <= WR_MASK;
                            start <= 1'b1;
                        end
                    end
                    RD_INT: begin
                        if (txn_done) begin
                            int_q <= rdata[COUNT-1:0];
                            state <= RD_STAT;
                            start <= 1'b1;
                        end
                    end
                    RD_STAT: begin
                        if (txn_done) begin
                            state <= PUBLISH;
                        end
                    end
                    PUBLISH: begin
                        snap_status <= rdata[COUNT-1:0];
                        snap_addr   <= rdata[ADDR_MSB:ADDR_LSB];
                        snap_int    <= int_q;
                        snap_valid  <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    discr_avm_txn #(
        .TIMEOUT(TIMEOUT)
    ) u_txn (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rnw              (rnw),
        .addr             (addr),
        .wdata            (wdata),
        .done             (txn_done),
        .rdata            (rdata),
        .timeout          (txn_timeout),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata     (avm_readdata)
    );

endmodule
